// File: rtl/led_bank_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_pkg : display mode encodings shared by led_bank and the mode     |
// |           decoder that drives it.                                  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package led_pkg;

  typedef enum logic [1:0] {
    LED_STATIC = 2'b00,
    LED_BLINK  = 2'b01,
    LED_PWM    = 2'b10,
    LED_ROTATE = 2'b11
  } led_mode_t;

endpackage
`default_nettype wire

// File: rtl/led_bank_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_bank_if : load bus from the datapath plus the LED drive.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface led_bank_if
  import led_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PWM_BITS = 4
) ();

  logic [WIDTH-1:0]    rx;
  logic                enable;
  led_mode_t           mode;
  logic [PWM_BITS-1:0] duty;
  logic [WIDTH-1:0]    leds;

  modport master (output rx, output enable, output mode, output duty, input leds);
  modport slave  (input rx, input enable, input mode, input duty, output leds);

endinterface
`default_nettype wire

// File: rtl/led_bank_tick_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_divider : free-running modulo-DIV prescaler, one-cycle tick   |
// |                while the count sits at DIV-1; clear restarts at 0. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tick_divider #(
  parameter int DIV = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;

  assign tick = (r_cnt == c_last);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_bank : latches an LED pattern on enable and drives it static,  |
// |            blinking, PWM-dimmed or as a rotating marquee.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module led_bank
  import led_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int BLINK_DIV = 8,
  parameter int PWM_BITS  = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  led_bank_if.slave  bus
);

  logic [WIDTH-1:0]    r_pattern;
  led_mode_t           r_mode;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_phase;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [WIDTH-1:0]    r_leds;

  logic                w_tick;
  logic [WIDTH-1:0]    w_rot;
  logic [WIDTH-1:0]    w_leds_next;

  tick_divider #(
    .DIV (BLINK_DIV)
  ) u_tick_divider (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (bus.enable),
    .tick    (w_tick)
  );

  generate
    if (WIDTH > 1) begin : g_rot_wide
      assign w_rot = {r_pattern[WIDTH-2:0], r_pattern[WIDTH-1]};
    end else begin : g_rot_single
      assign w_rot = r_pattern;
    end
  endgenerate

  // A load wins over any tick landing in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pattern <= '0;
      r_mode    <= LED_STATIC;
      r_duty    <= '0;
      r_phase   <= 1'b0;
      r_pwm_cnt <= '0;
    end else if (bus.enable) begin
      r_pattern <= bus.rx;
      r_mode    <= bus.mode;
      r_duty    <= bus.duty;
      r_phase   <= 1'b1;
      r_pwm_cnt <= '0;
    end else begin
      if (w_tick) begin
        r_phase <= ~r_phase;
        if (r_mode == LED_ROTATE) begin
          r_pattern <= w_rot;
        end
      end
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end
  end

  always_comb begin
    w_leds_next = r_pattern;
    case (r_mode)
      LED_STATIC: w_leds_next = r_pattern;
      LED_BLINK:  w_leds_next = r_phase ? r_pattern : '0;
      LED_PWM:    w_leds_next = (r_pwm_cnt < r_duty) ? r_pattern : '0;
      LED_ROTATE: w_leds_next = r_pattern;
      default:    w_leds_next = r_pattern;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_leds <= '0;
    end else begin
      r_leds <= w_leds_next;
    end
  end

  assign bus.leds = r_leds;

endmodule
`default_nettype wire

// File: tb/tb_led_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_led_bank : directed-vector bench for led_bank (4 LEDs, tick     |
// |               every 4 cycles, 4-bit PWM).                          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_led_bank;
  import led_pkg::*;

  logic clock;
  logic reset_n;
  int   vectors;
  int   errors;

  led_bank_if #(.WIDTH(4), .PWM_BITS(4)) bus ();

  led_bank #(
    .WIDTH     (4),
    .BLINK_DIV (4),
    .PWM_BITS  (4)
  ) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [3:0] pat, input led_mode_t m, input logic [3:0] d);
    bus.rx     = pat;
    bus.mode   = m;
    bus.duty   = d;
    bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    exp = 4'b0000;
    vectors++;
    if (bus.leds !== exp) begin
      errors++;
      $display("FAIL reset_initial leds=%b expected=%b", bus.leds, exp);
    end
    #3 reset_n = 1'b1;
    step();
    load(4'b1010, LED_BLINK, 4'd0);
    step();
    step();
    exp = 4'b1010;
    vectors++;
    if (bus.leds !== exp) begin
      errors++;
      $display("FAIL reset_pre_blink leds=%b expected=%b", bus.leds, exp);
    end
    #2 reset_n = 1'b0;
    #1;
    exp = 4'b0000;
    vectors++;
    if (bus.leds !== exp) begin
      errors++;
      $display("FAIL reset_async leds=%b expected=%b", bus.leds, exp);
    end
    #1 reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      vectors++;
      if (bus.leds !== exp) begin
        errors++;
        $display("FAIL reset_hold k=%0d leds=%b expected=%b", k, bus.leds, exp);
      end
    end
  endtask

  task automatic test_static();
    logic [3:0] exp;
    exp = 4'b1011;
    load(4'b1011, LED_STATIC, 4'd0);
    for (int k = 1; k <= 101; k++) begin
      step();
      bus.rx = 4'($urandom);
      vectors++;
      if (bus.leds !== exp) begin
        errors++;
        $display("FAIL static k=%0d leds=%b expected=%b", k, bus.leds, exp);
      end
    end
  endtask

  task automatic test_blink();
    logic [3:0] exp;
    load(4'b0110, LED_BLINK, 4'd0);
    for (int k = 1; k <= 22; k++) begin
      step();
      exp = (((k - 1) / 4) % 2 == 0) ? 4'b0110 : 4'b0000;
      vectors++;
      if (bus.leds !== exp) begin
        errors++;
        $display("FAIL blink k=%0d leds=%b expected=%b", k, bus.leds, exp);
      end
    end
    // Now two cycles into an off phase: reload must restart a full on phase.
    load(4'b1001, LED_BLINK, 4'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = (((k - 1) / 4) % 2 == 0) ? 4'b1001 : 4'b0000;
      vectors++;
      if (bus.leds !== exp) begin
        errors++;
        $display("FAIL blink_reload k=%0d leds=%b expected=%b", k, bus.leds, exp);
      end
    end
  endtask

  task automatic test_pwm();
    logic [3:0] exp;
    int         on_cnt;
    on_cnt = 0;
    load(4'b1111, LED_PWM, 4'd5);
    for (int k = 1; k <= 32; k++) begin
      step();
      exp = (((k - 1) % 16) < 5) ? 4'b1111 : 4'b0000;
      if (bus.leds === 4'b1111) on_cnt++;
      vectors++;
      if (bus.leds !== exp) begin
        errors++;
        $display("FAIL pwm5 k=%0d leds=%b expected=%b", k, bus.leds, exp);
      end
    end
    vectors++;
    if (on_cnt !== 10) begin
      errors++;
      $display("FAIL pwm5_on_count got=%0d expected=10", on_cnt);
    end
    load(4'b1111, LED_PWM, 4'd0);
    exp = 4'b0000;
    for (int k = 1; k <= 32; k++) begin
      step();
      vectors++;
      if (bus.leds !== exp) begin
        errors++;
        $display("FAIL pwm0 k=%0d leds=%b expected=%b", k, bus.leds, exp);
      end
    end
  endtask

  task automatic test_rotate();
    logic [3:0] seq [5];
    logic [3:0] exp;
    seq[0] = 4'b0001;
    seq[1] = 4'b0010;
    seq[2] = 4'b0100;
    seq[3] = 4'b1000;
    seq[4] = 4'b0001;
    load(4'b0001, LED_ROTATE, 4'd0);
    for (int k = 1; k <= 20; k++) begin
      step();
      exp = seq[(k - 1) / 4];
      vectors++;
      if (bus.leds !== exp) begin
        errors++;
        $display("FAIL rotate k=%0d leds=%b expected=%b", k, bus.leds, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] vals [6];
    logic [3:0] exp;
    vals[0] = 4'b0001;
    vals[1] = 4'b0011;
    vals[2] = 4'b0110;
    vals[3] = 4'b1100;
    vals[4] = 4'b1000;
    vals[5] = 4'b0101;
    // Three-cycle burst in BLINK: each value appears one cycle later.
    bus.mode   = LED_BLINK;
    bus.duty   = 4'd0;
    bus.enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.rx = vals[i];
      step();
      if (i > 0) begin
        exp = vals[i-1];
        vectors++;
        if (bus.leds !== exp) begin
          errors++;
          $display("FAIL b2b_blink i=%0d leds=%b expected=%b", i, bus.leds, exp);
        end
      end
    end
    bus.enable = 1'b0;
    step();
    exp = vals[2];
    vectors++;
    if (bus.leds !== exp) begin
      errors++;
      $display("FAIL b2b_blink_last leds=%b expected=%b", bus.leds, exp);
    end
    // Six-cycle ROTATE burst, longer than a tick period, then check shift timing.
    bus.mode   = LED_ROTATE;
    bus.enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.rx = vals[i];
      step();
      if (i > 0) begin
        exp = vals[i-1];
        vectors++;
        if (bus.leds !== exp) begin
          errors++;
          $display("FAIL b2b_rotate i=%0d leds=%b expected=%b", i, bus.leds, exp);
        end
      end
    end
    bus.enable = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp = (k <= 4) ? 4'b0101 : 4'b1010;
      vectors++;
      if (bus.leds !== exp) begin
        errors++;
        $display("FAIL b2b_rotate_after k=%0d leds=%b expected=%b", k, bus.leds, exp);
      end
    end
  endtask

  initial begin
    vectors    = 0;
    errors     = 0;
    reset_n    = 1'b1;
    bus.rx     = 4'b0000;
    bus.enable = 1'b0;
    bus.mode   = LED_STATIC;
    bus.duty   = 4'd0;
    test_reset();
    test_static();
    test_blink();
    test_pwm();
    test_rotate();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_bank.md
# led_bank

Parametrised LED output driver, successor to the 4-bit latch-and-hold LED register. Latches a WIDTH-bit pattern from the processor datapath on `enable`, then drives it in one of four display modes: static, blink, PWM-dimmed or rotating marquee. It sits between the register file output bus and the board LED pins. All outputs are registered.

## Interface
- `WIDTH`, 4, number of LED channels (≥1)
- `BLINK_DIV`, 8, clock cycles per blink/rotate tick (≥1)
- `PWM_BITS`, 4, PWM counter and duty width (≥1)

- `clock`  in  1  single clock, all state on posedge
- `reset_n`  in  1  asynchronous, active-low reset
- `rx`  in  WIDTH  pattern to load
- `enable`  in  1  load strobe: captures `rx`, `mode`, `duty` this edge
- `mode`  in  2  display mode: 00 STATIC, 01 BLINK, 10 PWM, 11 ROTATE
- `duty`  in  PWM_BITS  PWM on-count (used in PWM mode)
- `leds`  out  WIDTH  registered LED drive

## Operation
- Internal state: `pattern` (WIDTH), `mode_q` (2), `duty_q` (PWM_BITS), prescaler `div_cnt` (0..BLINK_DIV-1), `phase` (1), `pwm_cnt` (PWM_BITS).
- Reset (`reset_n`=0, asynchronous): `leds`=0, `pattern`=0, `mode_q`=STATIC, `duty_q`=0, `div_cnt`=0, `phase`=0, `pwm_cnt`=0. Reset mid-operation discards all state immediately.
- Load (`enable`=1 at posedge): `pattern`<=`rx`, `mode_q`<=`mode`, `duty_q`<=`duty`, `div_cnt`<=0, `phase`<=1, `pwm_cnt`<=0. Load takes priority over any tick or rotation in the same cycle.
- No load: `pattern`, `mode_q`, `duty_q` hold (behaviour of the original block in STATIC mode).
- Prescaler: `div_cnt` increments each cycle; at BLINK_DIV-1 it wraps to 0 and asserts `tick` for that cycle. BLINK_DIV=1 → `tick` every cycle.
- On `tick`: `phase` toggles. In ROTATE mode only, `pattern` rotates left by one (MSB → bit 0). WIDTH=1 → rotation is identity.
- `pwm_cnt` increments every cycle, wraps modulo 2^PWM_BITS.
- Next `leds` value by `mode_q`:
  - STATIC: `pattern`
  - BLINK: `pattern` if `phase`=1, else 0
  - PWM: `pattern` if `pwm_cnt` < `duty_q`, else 0. `duty_q`=0 → always dark; max duty → on 2^PWM_BITS-1 of 2^PWM_BITS cycles (full-on is STATIC).
  - ROTATE: `pattern` (already rotating)
- Unknown/X on `mode` is not defined; all four codes are legal.

## Timing
- `leds` is a register computed from current-cycle state: a load at edge N shows the new pattern on `leds` after edge N+1 (1-cycle latency).
- BLINK: after load at edge N, LEDs on for BLINK_DIV cycles, then off for BLINK_DIV, period 2·BLINK_DIV.
- ROTATE: first shift occurs BLINK_DIV cycles after load.
- PWM period 2^PWM_BITS cycles, phase-aligned to the last load.
- Back-to-back `enable` re-loads each cycle; counters stay held at their post-load values.

## Structure
- Shared package `led_pkg`: mode encodings `LED_STATIC`, `LED_BLINK`, `LED_PWM`, `LED_ROTATE` and the 2-bit mode type; used by the decoder that drives `mode`.
- One sub-module: `tick_divider` (parameter DIV, inputs `clock`, `reset_n`, `clear`; output `tick`), instantiated for the prescaler. `clear` = `enable`.
- Counter widths via `$clog2(BLINK_DIV)` (min 1).

## Test plan
Bench parameters: WIDTH=4, BLINK_DIV=4, PWM_BITS=4.
- Reset asserted mid-BLINK with `leds`=1010 → `leds`=0000 immediately; stays 0000 after release with no `enable`.
- `enable`, `rx`=1011, mode STATIC → `leds`=1011 one cycle later, unchanged 100 cycles later with `rx` toggling and `enable`=0.
- Load 0110, BLINK → `leds` 0110 for 4 cycles, 0000 for 4, repeating; reload mid-off-phase restarts with 4 on-cycles.
- Load 1111, PWM, `duty`=5 → exactly 5 of every 16 cycles `leds`=1111, rest 0000; `duty`=0 → constant 0000.
- Load 0001, ROTATE → `leds` sequence 0001,0010,0100,1000,0001, each held 4 cycles.
- `enable` held high 3 cycles with changing `rx` → `leds` follows each value with 1-cycle lag, no rotation or blink off-phase during the burst.
